// File: rtl/alu_pkg.sv
// Shared ALU opcode enum and flag payload for the pipelined ALU and its bench.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_SLT = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle between a producer, the ALU pipeline and its consumer.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_t          op;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, op, sat_en, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, sat_en, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: arithmetic/logic/shift ops, carry/overflow flags, signed saturation.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    input  logic             i_sat_en,
    output logic [WIDTH-1:0] o_result_c,
    output alu_flags_t       o_flags_c
);

    localparam int unsigned     SHW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff    = {1'b0, i_a} - {1'b0, i_b};
    assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1]  != i_a[WIDTH-1]);
    assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    assign w_slt     = $signed(i_a) < $signed(i_b);

    // Overflow direction always follows the sign of operand A for both ADD and SUB.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_add_ovf;
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = w_sub_ovf;
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_SHL: w_res = i_a << i_b[SHW-1:0];
            OP_SHR: w_res = i_a >> i_b[SHW-1:0];
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
        endcase
        if (i_sat_en && w_ovf) begin
            w_res = i_a[WIDTH-1] ? MAX_NEG : MAX_POS;
        end
    end

    assign o_result_c         = w_res;
    assign o_flags_c.carry    = w_carry;
    assign o_flags_c.overflow = w_ovf;
    assign o_flags_c.zero     = (w_res == '0);

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready pipelined ALU: compute ahead of stage 1, then STAGES-1 pure register stages.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    alu_pipe_if.slave  bus
);

    logic [WIDTH-1:0]  w_core_res;
    alu_flags_t        w_core_flg;
    logic              w_in_xfer;
    logic [STAGES-1:0] w_move;
    logic [STAGES-1:0] w_load;

    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_res [STAGES];
    alu_flags_t        r_flg [STAGES];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a        (bus.a),
        .i_b        (bus.b),
        .i_op       (bus.op),
        .i_sat_en   (bus.sat_en),
        .o_result_c (w_core_res),
        .o_flags_c  (w_core_flg)
    );

    // Ready ripples back from the consumer: a stage loads if empty or draining this cycle.
    always_comb begin
        logic w_free;
        w_free = bus.out_ready;
        w_move = '0;
        w_load = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            w_move[i] = r_vld[i] & w_free;
            w_load[i] = ~r_vld[i] | w_move[i];
            w_free    = w_load[i];
        end
    end

    assign bus.in_ready = ~rst & ~flush & w_load[0];
    assign w_in_xfer    = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                r_res[i] <= '0;
                r_flg[i] <= '0;
            end
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= w_in_xfer;
                r_res[0] <= w_core_res;
                r_flg[0] <= w_core_flg;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    r_res[i] <= r_res[i-1];
                    r_flg[i] <= r_flg[i-1];
                end
            end
        end
    end

    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.result    = r_res[STAGES-1];
    assign bus.carry     = r_flg[STAGES-1].carry;
    assign bus.overflow  = r_flg[STAGES-1].overflow;
    assign bus.zero      = r_flg[STAGES-1].zero;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits, legal range 4..32.
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages, legal range 1..4.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port flush  input  1  synchronous pipeline clear.
REQ-006 Port in_valid  input  1  operation present on a, b, op, sat_en.
REQ-007 Port in_ready  output  1  block can accept an operation this cycle.
REQ-008 Port a  input  WIDTH  operand A.
REQ-009 Port b  input  WIDTH  operand B.
REQ-010 Port op  input  3  opcode, alu_op_t.
REQ-011 Port sat_en  input  1  signed saturation for ADD/SUB.
REQ-012 Port out_valid  output  1  result present.
REQ-013 Port out_ready  input  1  consumer accepts result.
REQ-014 Port result  output  WIDTH  operation result.
REQ-015 Port carry  output  1  unsigned carry-out (ADD) / borrow (SUB); 0 for all other ops.
REQ-016 Port overflow  output  1  signed overflow of ADD/SUB before saturation; 0 otherwise.
REQ-017 Port zero  output  1  result == 0, after saturation.

Function
REQ-018 Opcodes SHALL be 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR logical, 7 SLT (result 1 if signed a<b, else 0).
REQ-019 Shift amount SHALL be b[$clog2(WIDTH)-1:0]; upper bits of b are ignored.
REQ-020 With sat_en=1 and ADD/SUB signed overflow, result SHALL clamp to the most-positive or most-negative WIDTH-bit value per overflow direction; sat_en SHALL be ignored for other ops.
REQ-021 Computation SHALL occur combinationally before stage 1; stages 2..STAGES SHALL be pure registers carrying result and flags.
REQ-022 A transfer SHALL occur on a cycle where valid and ready are both high; in_valid, a, b, op, sat_en are sampled only on input transfer.
REQ-023 Each stage SHALL load when it is empty or its content moves downstream that cycle; the last stage moves when out_ready=1.
REQ-024 in_ready SHALL be high when stage 1 is empty or stage 1 moves this cycle (combinational from out_ready through the chain).
REQ-025 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with out_ready held high; throughput one operation per cycle.
REQ-026 While out_valid=1 and out_ready=0, result and flags SHALL hold stable and no operation SHALL be lost or duplicated.
REQ-027 Results SHALL emerge in acceptance order.
REQ-028 flush=1 SHALL clear every stage valid at the next edge, force in_ready=0 that cycle and discard any coincident input; data registers need not clear.
REQ-029 flush together with an output transfer SHALL still count as a completed output transfer for the consumer.

Reset
REQ-030 rst=1 SHALL asynchronously clear all stage valids; out_valid=0, result=0, carry=0, overflow=0, zero=0 while held.
REQ-031 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after release.
REQ-032 Reset mid-stream SHALL discard all in-flight operations; none reappear after release.

Structure
REQ-033 Package alu_pkg SHALL hold alu_op_t enum and opcode constants, shared with the class-based bench.
REQ-034 Sub-module alu_core SHALL hold the purely combinational compute (ops, flags, saturation), parametrised by WIDTH.

Verification
REQ-035 WIDTH=8, STAGES=2: ADD a=0x7F b=0x01 sat_en=0 -> after 2 cycles result=0x80, overflow=1, carry=0, zero=0.
REQ-036 Same with sat_en=1 -> result=0x7F, overflow=1; SUB a=0x80 b=0x01 sat_en=1 -> result=0x80, overflow=1, carry=0.
REQ-037 ADD a=0xFF b=0x01 -> result=0x00, carry=1, zero=1; SLT a=0xFF b=0x01 -> result=0x01; SHL a=0x81 b=0x09 -> result=0x02.
REQ-038 Back-to-back 10 ops, out_ready low cycles 3-6 -> in_ready drops once both stages full, all 10 results in order, none duplicated.
REQ-039 Two ops in flight, flush=1 one cycle -> out_valid=0 next cycle, neither result ever appears; next op accepted following cycle.
REQ-040 rst asserted asynchronously mid-stream with out_valid=1 -> out_valid and flags 0 immediately; STAGES=1 and STAGES=4 re-run of REQ-035 gives latency 1 and 4.
